mac_accum: RTL
==============

// Module: mac_accum
// PURPOSE
//  Parametrised multiply-accumulate unit; successor to the standalone adder/mul pair.
//  Accepts a stream of (a,b) operand beats under valid/ready and multiplies each pair.
//  Sums the products into a wide accumulator until a beat flagged last, then presents the result under valid/ready.
//  Sits between an operand source (tester or data FIFO) and a result sink. Serves as the dot-product core for later labs.
// PARAMETERS
//  A       8   operand a width (bits)
//  B       8   operand b width (bits)
//  N_MAX   16  max terms per group; the N_MAX-th beat is an implicit last
//  ACC_W   20  accumulator/result width; must be >= A+B
//  CNT_W   5   term counter width, = $clog2(N_MAX+1)
// PORTS
//  i_clk      in   1      clock, rising edge
//  i_reset    in   1      asynchronous, active-high reset
//  i_valid    in   1      operand beat valid
//  o_ready    out  1      unit accepts a beat this cycle
//  i_a        in   A      operand a
//  i_b        in   B      operand b
//  i_last     in   1      beat closes the current group
//  i_signed   in   1      1: two's-complement operands/accumulate; 0: unsigned
//  o_valid    out  1      result valid
//  i_ready    in   1      sink accepts result
//  o_acc      out  ACC_W  accumulated sum
//  o_count    out  CNT_W  number of terms in o_acc
//  o_ovf      out  1      accumulator overflowed at least once in this group
// BEHAVIOUR
//  - Reset: async assert, sync release. All state clears: FSM=IDLE, o_valid=0, o_acc=0, o_count=0, o_ovf=0.
//    o_ready=0 while i_reset=1 and 1 from the first edge after release. In-flight products are discarded.
//  - Beat accepted on a rising edge with i_valid&&o_ready. i_a/i_b/i_last must stay stable while i_valid&&!o_ready.
//  - i_signed is sampled on the first beat of a group and held for the whole group. Later values are ignored until the next group.
//  - Pipeline: P1 registers the A+B-bit product, sign- or zero-extended to ACC_W. P2 adds it to the accumulator.
//  - FSM states:
//      IDLE: accumulator=0, count=0. First accepted beat -> ACC.
//      ACC: accepts beats. A beat with i_last, or a beat that makes count==N_MAX, closes the group.
//           o_ready drops the cycle after the closing beat, then -> HOLD once the product is added.
//      HOLD: o_valid=1; o_acc/o_count/o_ovf stable. On i_valid-output handshake (o_valid&&i_ready) -> IDLE.
//  - Latency: closing beat accepted at edge t -> o_valid=1 after edge t+2.
//  - o_ready=0 in HOLD and while a closing product is in flight. Otherwise 1.
//  - Throughput: 1 beat/cycle within a group; 2 bubble cycles + handshake between groups.
//  - Single-beat group (first beat has i_last): o_count=1, o_acc=product.
//  - Overflow: per-add detection in the active mode.
//      Unsigned: carry out of ACC_W.
//      Signed: operand signs equal and result sign differs.
//  - o_ovf is sticky within a group and clears on return to IDLE.
//  - Handshake at the HOLD->IDLE edge does not accept an input beat that same cycle (o_ready=0 in HOLD).
// CONFIGURATION
//  MAC_SAT_EN defined:
//    on overflow the accumulator clamps and stays clamped (further adds still checked).
//    Unsigned clamps to 2^ACC_W-1. Signed clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1) per overflow direction.
//  MAC_SAT_EN undefined: accumulator wraps modulo 2^ACC_W. o_ovf is flagged identically in both builds.
// TESTING
//  1 unsigned, beats (3,4),(5,6),(7,8,last) back-to-back -> o_acc=98, o_count=3, o_ovf=0.
//    o_valid two edges after the last beat.
//  2 signed, beats (-3,4),(127,-128,last) -> o_acc=-16268 (20-bit two's comp), o_count=2.
//  3 unsigned, 16 beats of (255,255) with no i_last -> implicit close at beat 16.
//    o_count=16, o_acc=1040400, o_ovf=0. 17th beat is held off by o_ready=0.
//  4 ACC_W=16 unsigned, (255,255),(255,255,last) -> o_ovf=1.
//    o_acc=0xFFFF with MAC_SAT_EN; o_acc=0xFC02 without it.
//  5 result sink holds i_ready=0 for 10 cycles -> o_valid/o_acc stable, o_ready=0.
//    Next group starts only after the handshake.
//  6 assert i_reset mid-group after 2 beats -> all outputs 0 immediately.
//    Fresh group (2,2,last) after release -> o_acc=4, o_count=1.

Source files
------------

// File: rtl/mac_accum.sv
// rtl/mac_accum.sv - streaming multiply-accumulate unit with grouped results (optional saturation: MAC_SAT_EN)
module mac_accum #(
    parameter int A     = 8,
    parameter int B     = 8,
    parameter int N_MAX = 16,
    parameter int ACC_W = 20,
    parameter int CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [A-1:0]     i_a,
    input  logic [B-1:0]     i_b,
    input  logic             i_last,
    input  logic             i_signed,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [ACC_W-1:0] o_acc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           state;
    logic             ready_q;
    logic             valid_q;
    logic             sgn_q;
    logic             ovf_q;
    logic             p1_vld;
    logic             p1_last;
    logic             p2_last;
    logic [ACC_W-1:0] p1_prod;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             closing;
    logic             sgn_eff;
    logic [ACC_W-1:0] a_w;
    logic [ACC_W-1:0] b_w;
    logic [ACC_W-1:0] prod_w;
    logic [ACC_W:0]   sum;
    logic             add_ovf;
    logic [ACC_W-1:0] acc_n;

    // Beat acceptance, group close detection and sign-mode selection for the incoming beat
    always_comb begin
        accept  = i_valid && ready_q;
        closing = i_last || (cnt_q == CNT_W'(N_MAX - 1));
        // The first beat of a group uses the live i_signed; later beats use the latched mode.
        sgn_eff = (state == S_IDLE) ? i_signed : sgn_q;
    end

    // Product stage: operands extended to ACC_W so the truncated product is already sign/zero extended
    always_comb begin
        a_w    = {{(ACC_W - A){sgn_eff & i_a[A-1]}}, i_a};
        b_w    = {{(ACC_W - B){sgn_eff & i_b[B-1]}}, i_b};
        prod_w = a_w * b_w;
    end

    // Accumulate stage: add, detect overflow in the group's mode, optionally clamp
    always_comb begin
        sum = {1'b0, acc_q} + {1'b0, p1_prod};
        if (sgn_q) begin
            add_ovf = (acc_q[ACC_W-1] == p1_prod[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
        end else begin
            add_ovf = sum[ACC_W];
        end
`ifdef MAC_SAT_EN
        // Once the group has overflowed the accumulator is frozen at its clamp value.
        if (ovf_q) begin
            acc_n = acc_q;
        end else if (add_ovf) begin
            if (!sgn_q) begin
                acc_n = {ACC_W{1'b1}};
            end else if (acc_q[ACC_W-1]) begin
                acc_n = {1'b1, {(ACC_W - 1){1'b0}}};
            end else begin
                acc_n = {1'b0, {(ACC_W - 1){1'b1}}};
            end
        end else begin
            acc_n = sum[ACC_W-1:0];
        end
`else
        acc_n = sum[ACC_W-1:0];
`endif
    end

    // Control FSM, two-stage datapath pipeline and registered handshake outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= S_IDLE;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            sgn_q   <= 1'b0;
            ovf_q   <= 1'b0;
            p1_vld  <= 1'b0;
            p1_last <= 1'b0;
            p2_last <= 1'b0;
            p1_prod <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            p1_vld  <= accept;
            p2_last <= p1_vld && p1_last;

            if (accept) begin
                p1_prod <= prod_w;
                p1_last <= closing;
                cnt_q   <= cnt_q + 1'b1;
                if (state == S_IDLE) begin
                    sgn_q <= i_signed;
                end
            end

            if (p1_vld) begin
                acc_q <= acc_n;
                ovf_q <= ovf_q | add_ovf;
            end

            // Ready drops right after the closing beat and returns only in IDLE
            // or on the result handshake.
            if (accept && closing) begin
                ready_q <= 1'b0;
            end else if (state == S_IDLE) begin
                ready_q <= 1'b1;
            end else if (state == S_HOLD && i_ready) begin
                ready_q <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (p2_last) begin
                        state   <= S_HOLD;
                        valid_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (i_ready) begin
                        state   <= S_IDLE;
                        valid_q <= 1'b0;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_acc   = acc_q;
    assign o_count = cnt_q;
    assign o_ovf   = ovf_q;

endmodule
